// File: rtl/segmented_display_arbiter.sv
// Time-shares one segmented display among several sources: round-robin ownership with a
// fixed dwell per turn, a blanking gap between owners, and per-source shadow frame buffers.
module segmented_display_arbiter #(
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int NUMBER_OF_NYBBLES    = 8,
  parameter int DWELL_CYCLES         = 50000000,
  parameter int BLANK_CYCLES         = 1000
) (
  input  logic                                                clock,
  input  logic                                                reset_n,
  input  logic [NUMBER_OF_REQUESTERS-1:0]                     request,
  input  logic [NUMBER_OF_REQUESTERS-1:0]                     load,
  input  logic [NUMBER_OF_REQUESTERS*NUMBER_OF_NYBBLES*4-1:0] data_in,
  input  logic [NUMBER_OF_REQUESTERS*NUMBER_OF_NYBBLES-1:0]   dp_in,
  output logic [NUMBER_OF_REQUESTERS-1:0]                     accepted,
  output logic [NUMBER_OF_REQUESTERS-1:0]                     grant,
  output logic                                                active,
  output logic [NUMBER_OF_NYBBLES*4-1:0]                      data,
  output logic [NUMBER_OF_NYBBLES-1:0]                        dp
);

  localparam int NREQ    = NUMBER_OF_REQUESTERS;
  localparam int FRAME_W = NUMBER_OF_NYBBLES * 4;
  localparam int DP_W    = NUMBER_OF_NYBBLES;
  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NREQ - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [IDX_W-1:0]   r_lastGrant;
  logic [DWELL_W-1:0] r_dwell;
  logic [BLANK_W-1:0] r_blank;
  logic [FRAME_W-1:0] r_shadowData [NREQ];
  logic [DP_W-1:0]    r_shadowDp   [NREQ];

  logic               w_found;
  logic [IDX_W-1:0]   w_probe;
  logic [IDX_W-1:0]   w_winIdx;
  logic               w_take;
  logic [NREQ-1:0]    w_ownerMask;
  logic [IDX_W-1:0]   w_nextIdx;
  logic [NREQ-1:0]    w_nextGrant;
  logic [FRAME_W-1:0] w_nextData;
  logic [DP_W-1:0]    w_nextDp;

  // Round-robin search starts just above the previous owner and wraps.
  always_comb begin
    w_found  = 1'b0;
    w_probe  = '0;
    w_winIdx = r_lastGrant;
    for (int k = 1; k <= NREQ; k++) begin
      w_probe = IDX_W'((int'(r_lastGrant) + k) % NREQ);
      if (!w_found && request[w_probe]) begin
        w_found  = 1'b1;
        w_winIdx = w_probe;
      end
    end
  end

  assign w_ownerMask = NREQ'(1) << r_lastGrant;

  always_comb begin
    w_nextState = r_state;
    w_take      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|request) begin
          w_nextState = SHOW;
          w_take      = 1'b1;
        end
      end
      SHOW: begin
        if (!request[r_lastGrant]) begin
          w_nextState = BLANK;
        end else if (r_dwell == DWELL_LAST && |(request & ~w_ownerMask)) begin
          w_nextState = BLANK;
        end
      end
      BLANK: begin
        if (r_blank == BLANK_LAST) begin
          if (|request) begin
            w_nextState = SHOW;
            w_take      = 1'b1;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered, so they are registered yet not late.
  always_comb begin
    w_nextIdx   = w_take ? w_winIdx : r_lastGrant;
    w_nextGrant = '0;
    w_nextData  = '0;
    w_nextDp    = '0;
    if (w_nextState == SHOW) begin
      w_nextGrant = NREQ'(1) << w_nextIdx;
      w_nextData  = r_shadowData[w_nextIdx];
      w_nextDp    = r_shadowDp[w_nextIdx];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_lastGrant <= LAST_IDX;
      r_dwell     <= '0;
      r_blank     <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_take) r_lastGrant <= w_winIdx;
      r_dwell <= (r_state == SHOW && w_nextState == SHOW && r_dwell != DWELL_LAST)
                 ? r_dwell + 1'b1 : '0;
      r_blank <= (r_state == BLANK && w_nextState == BLANK) ? r_blank + 1'b1 : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant    <= '0;
      active   <= 1'b0;
      data     <= '0;
      dp       <= '0;
      accepted <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_shadowData[i] <= '0;
        r_shadowDp[i]   <= '0;
      end
    end else begin
      grant    <= w_nextGrant;
      active   <= (w_nextState == SHOW);
      data     <= w_nextData;
      dp       <= w_nextDp;
      accepted <= load;
      for (int i = 0; i < NREQ; i++) begin
        if (load[i]) begin
          r_shadowData[i] <= data_in[i*FRAME_W +: FRAME_W];
          r_shadowDp[i]   <= dp_in[i*DP_W +: DP_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_segmented_display_arbiter.sv
// Randomized bench for segmented_display_arbiter: a turn-based model with countdown timers
// predicts every registered output after each clock edge.
module tb_segmented_display_arbiter;

  localparam int NREQ  = 4;
  localparam int NYB   = 8;
  localparam int DWELL = 16;
  localparam int BLANK = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [3:0]     request = '0;
  logic [3:0]     load = '0;
  logic [127:0]   dataIn = '0;
  logic [31:0]    dpIn = '0;
  logic [3:0]     accepted;
  logic [3:0]     grant;
  logic           active;
  logic [31:0]    data;
  logic [7:0]     dp;

  segmented_display_arbiter #(
    .NUMBER_OF_REQUESTERS(NREQ),
    .NUMBER_OF_NYBBLES(NYB),
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .request(request),
    .load(load),
    .data_in(dataIn),
    .dp_in(dpIn),
    .accepted(accepted),
    .grant(grant),
    .active(active),
    .data(data),
    .dp(dp)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int failCount  = 0;

  // Model: owner is -1 when nobody holds the display; timers count down remaining cycles.
  int          owner;
  int          lastOwner;
  int          dwellLeft;
  int          blankLeft;
  logic [31:0] shadowData [NREQ];
  logic [7:0]  shadowDp   [NREQ];
  logic [3:0]  expAccepted;
  logic [3:0]  expGrant;
  logic        expActive;
  logic [31:0] expData;
  logic [7:0]  expDp;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pickWinner(input logic [3:0] req, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelReset();
    owner     = -1;
    lastOwner = NREQ - 1;
    dwellLeft = 0;
    blankLeft = 0;
    for (int i = 0; i < NREQ; i++) begin
      shadowData[i] = '0;
      shadowDp[i]   = '0;
    end
    expAccepted = '0;
    expGrant    = '0;
    expActive   = 1'b0;
    expData     = '0;
    expDp       = '0;
  endtask

  task automatic grantTo(input int who);
    owner     = who;
    lastOwner = who;
    dwellLeft = DWELL;
  endtask

  task automatic modelEdge();
    if (!reset_n) begin
      modelReset();
      return;
    end
    if (owner >= 0) begin
      if (!request[owner]) begin
        owner     = -1;
        blankLeft = BLANK;
      end else begin
        dwellLeft--;
        if (dwellLeft == 0) begin
          if ((request & ~(4'b0001 << owner)) != 4'b0000) begin
            owner     = -1;
            blankLeft = BLANK;
          end else begin
            dwellLeft = DWELL;
          end
        end
      end
    end else if (blankLeft > 0) begin
      blankLeft--;
      if (blankLeft == 0 && request != 4'b0000) grantTo(pickWinner(request, lastOwner));
    end else if (request != 4'b0000) begin
      grantTo(pickWinner(request, lastOwner));
    end
    expAccepted = load;
    expGrant    = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    expActive   = (owner >= 0);
    expData     = (owner >= 0) ? shadowData[owner] : 32'h0;
    expDp       = (owner >= 0) ? shadowDp[owner] : 8'h0;
    for (int i = 0; i < NREQ; i++) begin
      if (load[i]) begin
        shadowData[i] = dataIn[i*32 +: 32];
        shadowDp[i]   = dpIn[i*8 +: 8];
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("accepted", 64'(accepted), 64'(expAccepted));
    checkOutput("grant",    64'(grant),    64'(expGrant));
    checkOutput("active",   64'(active),   64'(expActive));
    checkOutput("data",     64'(data),     64'(expData));
    checkOutput("dp",       64'(dp),       64'(expDp));
  endtask

  task automatic stepCycle();
    @(posedge clock);
    modelEdge();
    #1;
    checkAll();
    load = '0;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] ld, input int cycles);
    request = req;
    load    = ld;
    repeat (cycles) stepCycle();
  endtask

  // Reset is asserted between edges so outputs must clear with no clock involved.
  task automatic pulseReset();
    reset_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #3;
    checkAll();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    dataIn[2*32 +: 32] = 32'h12345678;
    dpIn[2*8 +: 8]     = 8'hA5;
    applyStimulus(4'b0000, 4'b0100, 1);
    checkOutput("acceptLoad2", 64'(accepted), 64'h4);
    applyStimulus(4'b0100, 4'b0000, 1);
    checkOutput("grantSrc2", 64'(grant), 64'h4);
    checkOutput("activeSrc2", 64'(active), 64'h1);
    checkOutput("frameSrc2", 64'(data), 64'h12345678);
    applyStimulus(4'b0100, 4'b0000, 50);
    checkOutput("grantSrc2Held", 64'(grant), 64'h4);

    applyStimulus(4'b1001, 4'b0000, 3 * (DWELL + BLANK) + 2);

    pulseReset();
    applyStimulus(4'b0001, 4'b0000, 1);
    checkOutput("grantSrc0", 64'(grant), 64'h1);
    applyStimulus(4'b0011, 4'b0000, 5);
    applyStimulus(4'b0010, 4'b0000, 1);
    checkOutput("blankAfterDrop", 64'(grant), 64'h0);
    applyStimulus(4'b0010, 4'b0000, BLANK);
    checkOutput("grantSrc1", 64'(grant), 64'h2);

    dataIn[1*32 +: 32] = 32'hCAFE0001;
    dpIn[1*8 +: 8]     = 8'h3C;
    applyStimulus(4'b0010, 4'b0010, 1);
    checkOutput("acceptLoad1", 64'(accepted), 64'h2);
    applyStimulus(4'b0010, 4'b0000, 1);
    checkOutput("frameSrc1", 64'(data), 64'hCAFE0001);
    checkOutput("acceptDropped", 64'(accepted), 64'h0);

    applyStimulus(4'b0001, 4'b0000, 1);
    applyStimulus(4'b0000, 4'b0000, BLANK);
    checkOutput("idleGrant", 64'(grant), 64'h0);
    checkOutput("idleActive", 64'(active), 64'h0);

    applyStimulus(4'b0100, 4'b0000, 3);
    pulseReset();

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(23) == 0) request = 4'($urandom);
      load   = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      dataIn = {$urandom, $urandom, $urandom, $urandom};
      dpIn   = $urandom;
      if ($urandom_range(400) == 0) pulseReset();
      else stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
